// File: rtl/bg_fetch_arbiter_pkg.sv
// Shared types and widths for the background ROM fetch arbiter.
package bg_pkg;

  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 5;
  localparam int COORD_W  = 10;
  localparam int BG_W_DEF = 320;
  localparam int BG_H_DEF = 480;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_QUERY
  } owner_t;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_WAIT,
    Q_DONE
  } q_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   in_range;
  } slot_tag_t;

endpackage

// File: rtl/bg_fetch_arbiter_addr_gen.sv
// Screen coordinate to background ROM address, with range check.
module bg_addr_gen
  import bg_pkg::*;
#(
  parameter int BG_W    = BG_W_DEF,
  parameter int BG_H    = BG_H_DEF,
  parameter int SCALE_X = 1,
  parameter int SCALE_Y = 0
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_in_range
);

  logic [COORD_W-1:0] w_tx;
  logic [COORD_W-1:0] w_ty;

  assign w_tx       = i_x >> SCALE_X;
  assign w_ty       = i_y >> SCALE_Y;
  assign o_addr     = ADDR_W'(w_ty) * ADDR_W'(BG_W) + ADDR_W'(w_tx);
  assign o_in_range = (int'(w_tx) < BG_W) && (int'(w_ty) < BG_H);

endmodule

// File: rtl/bg_fetch_arbiter.sv
// Shares the single-port background ROM between VGA scanout (absolute priority)
// and a game-logic colour query port served in free slots.
module bg_fetch_arbiter
  import bg_pkg::*;
#(
  parameter int BG_W    = BG_W_DEF,
  parameter int BG_H    = BG_H_DEF,
  parameter int SCALE_X = 1,
  parameter int SCALE_Y = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pix_en,
  input  logic               i_blank,
  input  logic [COORD_W-1:0] i_draw_x,
  input  logic [COORD_W-1:0] i_draw_y,
  output logic [PIX_W-1:0]   o_bg_pixel,
  output logic               o_bg_pixel_valid,
  input  logic               i_q_req,
  input  logic [COORD_W-1:0] i_q_x,
  input  logic [COORD_W-1:0] i_q_y,
  output logic               o_q_ack,
  output logic [PIX_W-1:0]   o_q_data,
  output logic               o_q_busy,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [PIX_W-1:0]   i_rom_data
);

  // Q_IDLE: free, may grant | Q_WAIT: read in flight | Q_DONE: ack cycle
  q_state_t          r_q_state;
  q_state_t          w_q_state_nxt;

  slot_tag_t         r_tag0;
  slot_tag_t         r_tag1;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [PIX_W-1:0]  r_bg_pixel;
  logic              r_bg_valid;
  logic              r_q_ack;
  logic [PIX_W-1:0]  r_q_data;
  logic              r_q_busy;

  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_disp_in_range;
  logic [ADDR_W-1:0] w_q_addr;
  logic              w_q_in_range;
  logic              w_disp_slot;
  logic              w_q_grant;
  logic              w_q_capture;
  owner_t            w_owner;
  logic [ADDR_W-1:0] w_slot_addr;
  logic              w_slot_in_range;

  bg_addr_gen #(
    .BG_W    (BG_W),
    .BG_H    (BG_H),
    .SCALE_X (SCALE_X),
    .SCALE_Y (SCALE_Y)
  ) u_disp_addr (
    .i_x        (i_draw_x),
    .i_y        (i_draw_y),
    .o_addr     (w_disp_addr),
    .o_in_range (w_disp_in_range)
  );

  bg_addr_gen #(
    .BG_W    (BG_W),
    .BG_H    (BG_H),
    .SCALE_X (SCALE_X),
    .SCALE_Y (SCALE_Y)
  ) u_query_addr (
    .i_x        (i_q_x),
    .i_y        (i_q_y),
    .o_addr     (w_q_addr),
    .o_in_range (w_q_in_range)
  );

  assign w_disp_slot = i_pix_en && !i_blank;
  assign w_q_grant   = !w_disp_slot && (r_q_state == Q_IDLE) && i_q_req;
  // The query's tag is in stage 1 exactly when its ROM word is on i_rom_data.
  assign w_q_capture = (r_q_state == Q_WAIT) && r_tag1.valid && (r_tag1.owner == OWN_QUERY);

  always_comb begin
    w_owner         = OWN_NONE;
    w_slot_addr     = w_disp_addr;
    w_slot_in_range = 1'b0;
    if (w_disp_slot) begin
      w_owner         = OWN_DISP;
      w_slot_addr     = w_disp_addr;
      w_slot_in_range = w_disp_in_range;
    end else if (w_q_grant) begin
      w_owner         = OWN_QUERY;
      w_slot_addr     = w_q_addr;
      w_slot_in_range = w_q_in_range;
    end
  end

  always_comb begin
    w_q_state_nxt = r_q_state;
    case (r_q_state)
      Q_IDLE:  if (w_q_grant) w_q_state_nxt = Q_WAIT;
      Q_WAIT:  if (w_q_capture) w_q_state_nxt = Q_DONE;
      Q_DONE:  w_q_state_nxt = Q_IDLE;
      default: w_q_state_nxt = Q_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q_state <= Q_IDLE;
    end else begin
      r_q_state <= w_q_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rom_addr      <= '0;
      r_tag0          <= '0;
      r_tag1          <= '0;
      r_bg_pixel      <= '0;
      r_bg_valid      <= 1'b0;
      r_q_ack         <= 1'b0;
      r_q_data        <= '0;
      r_q_busy        <= 1'b0;
    end else begin
      // Out-of-range slots leave the ROM address alone but still carry a tag.
      if ((w_owner != OWN_NONE) && w_slot_in_range) begin
        r_rom_addr <= w_slot_addr;
      end
      r_tag0.valid    <= (w_owner != OWN_NONE);
      r_tag0.owner    <= w_owner;
      r_tag0.in_range <= w_slot_in_range;
      r_tag1          <= r_tag0;

      r_bg_valid <= 1'b0;
      if (r_tag1.valid && (r_tag1.owner == OWN_DISP)) begin
        r_bg_valid <= 1'b1;
        r_bg_pixel <= r_tag1.in_range ? i_rom_data : '0;
      end

      r_q_ack <= 1'b0;
      if (w_q_capture) begin
        r_q_ack  <= 1'b1;
        r_q_data <= r_tag1.in_range ? i_rom_data : '0;
      end

      if (w_q_grant) begin
        r_q_busy <= 1'b1;
      end else if (r_q_state == Q_DONE) begin
        r_q_busy <= 1'b0;
      end
    end
  end

  assign o_rom_addr       = r_rom_addr;
  assign o_bg_pixel       = r_bg_pixel;
  assign o_bg_pixel_valid = r_bg_valid;
  assign o_q_ack          = r_q_ack;
  assign o_q_data         = r_q_data;
  assign o_q_busy         = r_q_busy;

endmodule

// File: tb/tb_bg_fetch_arbiter.sv
// Directed bench for bg_fetch_arbiter with a registered-read ROM model.
module tb_bg_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        blank;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [4:0]  bg_pixel;
  logic        bg_pixel_valid;
  logic        q_req;
  logic [9:0]  q_x;
  logic [9:0]  q_y;
  logic        q_ack;
  logic [4:0]  q_data;
  logic        q_busy;
  logic [18:0] rom_addr;
  logic [4:0]  rom_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bg_fetch_arbiter dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_pix_en         (pix_en),
    .i_blank          (blank),
    .i_draw_x         (draw_x),
    .i_draw_y         (draw_y),
    .o_bg_pixel       (bg_pixel),
    .o_bg_pixel_valid (bg_pixel_valid),
    .i_q_req          (q_req),
    .i_q_x            (q_x),
    .i_q_y            (q_y),
    .o_q_ack          (q_ack),
    .o_q_data         (q_data),
    .o_q_busy         (q_busy),
    .o_rom_addr       (rom_addr),
    .i_rom_data       (rom_data)
  );

  // ROM contents: address 965 holds 0x1A, everything else a folded checksum + 1.
  function automatic logic [4:0] rom_word(input logic [18:0] a);
    if (a == 19'd965) return 5'h1A;
    return a[4:0] + a[9:5] + a[14:10] + {1'b0, a[18:15]} + 5'd1;
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  bit         pe [0:1299];
  logic [4:0] ep [0:1302];
  bit         qa;
  int         qs;
  int         qk;
  logic [4:0] qexp;
  logic [18:0] qaddr;

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    blank  = 1'b0;
    draw_x = '0;
    draw_y = '0;
    q_req  = 1'b0;
    q_x    = '0;
    q_y    = '0;
    tick();
    tick();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_bg_pixel", bg_pixel, 0);
    check("rst_bg_valid", bg_pixel_valid, 0);
    check("rst_q_ack", q_ack, 0);
    check("rst_q_data", q_data, 0);
    check("rst_q_busy", q_busy, 0);
    reset = 1'b0;
    tick();

    // Display fetch of (10,3) -> address 965
    pix_en = 1'b1; draw_x = 10'd10; draw_y = 10'd3;
    tick();
    pix_en = 1'b0;
    check("disp_addr", rom_addr, 965);
    check("disp_v_n1", bg_pixel_valid, 0);
    tick();
    check("disp_v_n2", bg_pixel_valid, 0);
    tick();
    check("disp_v_n3", bg_pixel_valid, 1);
    check("disp_pix", bg_pixel, 5'h1A);
    tick();
    check("disp_v_n4", bg_pixel_valid, 0);
    check("disp_hold", bg_pixel, 5'h1A);

    // Blanked strobe must not fetch or pulse
    pix_en = 1'b1; blank = 1'b1; draw_x = '0; draw_y = '0;
    tick();
    pix_en = 1'b0; blank = 1'b0;
    check("blank_addr", rom_addr, 965);
    for (int i = 0; i < 3; i++) begin
      check("blank_valid", bg_pixel_valid, 0);
      tick();
    end

    // Corner query (639,479) -> 153599
    q_req = 1'b1; q_x = 10'd639; q_y = 10'd479;
    tick();
    check("q1_addr", rom_addr, 153599);
    check("q1_busy_g1", q_busy, 1);
    check("q1_ack_g1", q_ack, 0);
    tick();
    check("q1_busy_g2", q_busy, 1);
    check("q1_ack_g2", q_ack, 0);
    tick();
    check("q1_ack", q_ack, 1);
    check("q1_data", q_data, 24);
    check("q1_busy_g3", q_busy, 1);
    q_req = 1'b0;
    tick();
    check("q1_ack_off", q_ack, 0);
    check("q1_busy_off", q_busy, 0);
    check("q1_data_hold", q_data, 24);

    // Simultaneous display (0,0) and query (2,0)
    pix_en = 1'b1; draw_x = '0; draw_y = '0;
    q_req = 1'b1; q_x = 10'd2; q_y = '0;
    tick();
    pix_en = 1'b0;
    check("sim_disp_addr", rom_addr, 0);
    check("sim_busy_wait", q_busy, 0);
    tick();
    check("sim_q_addr", rom_addr, 1);
    check("sim_busy", q_busy, 1);
    tick();
    check("sim_disp_v", bg_pixel_valid, 1);
    check("sim_disp_pix", bg_pixel, 1);
    check("sim_q_ack_early", q_ack, 0);
    tick();
    check("sim_q_ack", q_ack, 1);
    check("sim_q_data", q_data, 2);
    check("sim_disp_v_off", bg_pixel_valid, 0);
    q_req = 1'b0;
    tick();

    // Out-of-range query (640,0)
    q_req = 1'b1; q_x = 10'd640; q_y = '0;
    tick();
    check("oor_addr", rom_addr, 1);
    check("oor_busy", q_busy, 1);
    tick();
    tick();
    check("oor_ack", q_ack, 1);
    check("oor_data", q_data, 0);
    q_req = 1'b0;
    tick();

    // Reset one cycle after a grant, request left high
    q_req = 1'b1; q_x = 10'd20; q_y = 10'd2;
    tick();
    check("rr_busy_pre", q_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_busy_rst", q_busy, 0);
    check("rr_ack_rst", q_ack, 0);
    check("rr_addr_rst", rom_addr, 0);
    tick();
    check("rr_no_stale_ack", q_ack, 0);
    check("rr_regrant_busy", q_busy, 1);
    check("rr_regrant_addr", rom_addr, 650);
    tick();
    check("rr_ack_early", q_ack, 0);
    tick();
    check("rr_ack", q_ack, 1);
    check("rr_data", q_data, 31);
    q_req = 1'b0;
    tick();
    check("rr_busy_off", q_busy, 0);
    tick();
    tick();

    // Alternating display strobes with back-to-back queries
    qa = 1'b0; qk = 0; qs = 0; qexp = '0;
    for (int c = 0; c < 1300; c++) begin
      if (c >= 3 && pe[c-3]) begin
        check("run_valid", bg_pixel_valid, 1);
        check("run_pix", bg_pixel, ep[c]);
      end else begin
        check("run_valid", bg_pixel_valid, 0);
      end

      if (q_ack) begin
        check("run_q_owned", qa, 1);
        check("run_q_data", q_data, qexp);
        check("run_q_lat", (c - qs) <= 5, 1);
        qa = 1'b0;
        q_req = 1'b0;
      end else begin
        if (qa && (c - qs) > 8) begin
          check("run_q_timeout", 0, 1);
          qa = 1'b0;
          q_req = 1'b0;
        end
        if (!qa && c < 1270) begin
          q_x   = 10'((qk * 37) % 640);
          q_y   = 10'((qk * 13) % 480);
          qaddr = 19'(int'(q_y) * 320 + (int'(q_x) >> 1));
          qexp  = rom_word(qaddr);
          q_req = 1'b1;
          qa    = 1'b1;
          qs    = c;
          qk++;
        end
      end

      pe[c]  = (c % 2 == 0) && (c < 1280);
      pix_en = pe[c];
      draw_x = 10'(c / 2);
      draw_y = 10'd7;
      if (pe[c]) ep[c+3] = rom_word(19'(7 * 320 + ((c / 2) >> 1)));
      tick();
    end
    pix_en = 1'b0;
    q_req  = 1'b0;
    tick();
    check("run_q_left", qa, 0);
    check("run_q_count", qk > 300, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
